// File: rtl/alu_pkg.sv
// Shared encodings for the slice-serial 74181-style ALU: function selects,
// mode values and controller state encoding.
package alu_pkg;

    // Arithmetic selects (m = MODE_ARITH)
    localparam logic [3:0] S_PASS_A = 4'b0000;
    localparam logic [3:0] S_SUB    = 4'b0110;
    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_DBL    = 4'b1100;
    localparam logic [3:0] S_DEC    = 4'b1111;

    // Logic selects (m = MODE_LOGIC)
    localparam logic [3:0] S_NOT_A  = 4'b0000;
    localparam logic [3:0] S_XOR    = 4'b0110;
    localparam logic [3:0] S_AND    = 4'b1011;
    localparam logic [3:0] S_OR     = 4'b1110;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_slice_4.sv
// Combinational 4-bit 74181 equivalent (active-high data, true carry).
// The function is formed as X + Y + cin, where X depends on s[1:0] and
// Y on s[3:2]; logic mode returns the carry-free half-sum ~(X ^ Y).
module alu_slice_4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout
);

    logic [3:0] x_term;
    logic [3:0] y_term;
    logic [4:0] sum;

    // Build the two addend terms and the selected result
    always_comb begin
        case (s[1:0])
            2'b00:   x_term = a;
            2'b01:   x_term = a | b;
            2'b10:   x_term = a | ~b;
            default: x_term = 4'hF;
        endcase
        case (s[3:2])
            2'b00:   y_term = 4'h0;
            2'b01:   y_term = a & ~b;
            2'b10:   y_term = a & b;
            default: y_term = a;
        endcase
        sum = {1'b0, x_term} + {1'b0, y_term} + {4'b0000, cin};
        if (m == MODE_LOGIC) begin
            f    = ~(x_term ^ y_term);
            cout = 1'b0;
        end else begin
            f    = sum[3:0];
            cout = sum[4];
        end
    end

endmodule

// File: rtl/slice_serial_alu.sv
// Multi-cycle 74181-style ALU. Operands are evaluated 4*LANES bits per clock,
// least significant group first, with the inter-group carry held in carry_q.
// Valid/ready handshake on both sides; the result is held until consumed.
module slice_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             aeqb
);

    localparam int unsigned GW    = 4 * LANES;
    localparam int unsigned NG    = WIDTH / GW;
    localparam int unsigned IDX_W = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NG - 1);
    localparam logic [WIDTH-1:0] GRP_MASK = WIDTH'({GW{1'b1}});

    alu_state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             aeqb_q, aeqb_d;

    logic             accept;
    logic             last_grp;
    logic [31:0]      base;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [GW-1:0]    grp_a;
    logic [GW-1:0]    grp_b;
    logic [GW-1:0]    grp_f;
    logic [WIDTH-1:0] grp_f_ext;
    logic [LANES:0]   lane_c;

    assign accept   = in_valid & in_ready;
    assign last_grp = (idx_q == LAST_IDX);

    // Select the operand group addressed by idx_q
    always_comb begin
        base      = 32'(idx_q) * GW;
        a_sh      = a_q >> base;
        b_sh      = b_q >> base;
        grp_a     = a_sh[GW-1:0];
        grp_b     = b_sh[GW-1:0];
        grp_f_ext = WIDTH'(grp_f);
    end

    assign lane_c[0] = carry_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        alu_slice_4 u_slice (
            .a    (grp_a[4*l +: 4]),
            .b    (grp_b[4*l +: 4]),
            .s    (s_q),
            .m    (m_q),
            .cin  (lane_c[l]),
            .f    (grp_f[4*l +: 4]),
            .cout (lane_c[l+1])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (last_grp) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; in_ready depends on state and out_ready only
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath next values: latch on accept, one group per BUSY cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        f_d     = f_q;
        cout_d  = cout_q;
        aeqb_d  = aeqb_q;
        if (state_q == ST_BUSY) begin
            f_d     = (f_q & ~(GRP_MASK << base)) | (grp_f_ext << base);
            carry_d = lane_c[LANES];
            if (last_grp) begin
                idx_d  = '0;
                cout_d = lane_c[LANES] & ~m_q;
                aeqb_d = &f_d;
            end else begin
                idx_d  = idx_q + IDX_W'(1);
            end
        end else if (accept) begin
            a_d     = a;
            b_d     = b;
            s_d     = s;
            m_d     = m;
            carry_d = cin & ~m;
            idx_d   = '0;
        end
    end

    // Datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            aeqb_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            aeqb_q  <= aeqb_d;
        end
    end

    assign f    = f_q;
    assign cout = cout_q;
    assign aeqb = aeqb_q;

endmodule

// File: tb/tb_slice_serial_alu.sv
// Bench for slice_serial_alu: one instance with LANES=1 (4-cycle latency)
// and one with LANES=4 (1-cycle latency), checked against a table model.
module tb_slice_serial_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [2];
    logic        in_ready_o[2];
    logic [15:0] a_i       [2];
    logic [15:0] b_i       [2];
    logic [3:0]  s_i       [2];
    logic        m_i       [2];
    logic        cin_i     [2];
    logic        out_valid_o[2];
    logic        out_ready [2];
    logic [15:0] f_o       [2];
    logic        cout_o    [2];
    logic        aeqb_o    [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    slice_serial_alu #(.WIDTH(16), .LANES(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready_o[0]),
        .a(a_i[0]), .b(b_i[0]), .s(s_i[0]), .m(m_i[0]), .cin(cin_i[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready[0]),
        .f(f_o[0]), .cout(cout_o[0]), .aeqb(aeqb_o[0])
    );

    slice_serial_alu #(.WIDTH(16), .LANES(4)) u_dut_l4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready_o[1]),
        .a(a_i[1]), .b(b_i[1]), .s(s_i[1]), .m(m_i[1]), .cin(cin_i[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready[1]),
        .f(f_o[1]), .cout(cout_o[1]), .aeqb(aeqb_o[1])
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // 74181 function table, active-high data. Arithmetic rows are written as
    // "P plus Q plus cin" with -1 represented as all ones, so the 17th bit is
    // the true carry-out.
    function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
        logic [15:0] lg;
        logic [16:0] p, q;
        if (m) begin
            case (s)
                4'd0:    lg = ~a;
                4'd1:    lg = ~(a | b);
                4'd2:    lg = ~a & b;
                4'd3:    lg = 16'h0000;
                4'd4:    lg = ~(a & b);
                4'd5:    lg = ~b;
                4'd6:    lg = a ^ b;
                4'd7:    lg = a & ~b;
                4'd8:    lg = ~a | b;
                4'd9:    lg = ~(a ^ b);
                4'd10:   lg = b;
                4'd11:   lg = a & b;
                4'd12:   lg = 16'hFFFF;
                4'd13:   lg = a | ~b;
                4'd14:   lg = a | b;
                default: lg = a;
            endcase
            return {1'b0, lg};
        end
        case (s)
            4'd0:    begin p = {1'b0, a};      q = 17'h0; end
            4'd1:    begin p = {1'b0, a | b};  q = 17'h0; end
            4'd2:    begin p = {1'b0, a | ~b}; q = 17'h0; end
            4'd3:    begin p = 17'h0FFFF;      q = 17'h0; end
            4'd4:    begin p = {1'b0, a};      q = {1'b0, a & ~b}; end
            4'd5:    begin p = {1'b0, a | b};  q = {1'b0, a & ~b}; end
            4'd6:    begin p = {1'b0, a};      q = {1'b0, ~b}; end
            4'd7:    begin p = {1'b0, a & ~b}; q = 17'h0FFFF; end
            4'd8:    begin p = {1'b0, a};      q = {1'b0, a & b}; end
            4'd9:    begin p = {1'b0, a};      q = {1'b0, b}; end
            4'd10:   begin p = {1'b0, a | ~b}; q = {1'b0, a & b}; end
            4'd11:   begin p = {1'b0, a & b};  q = 17'h0FFFF; end
            4'd12:   begin p = {1'b0, a};      q = {1'b0, a}; end
            4'd13:   begin p = {1'b0, a | b};  q = {1'b0, a}; end
            4'd14:   begin p = {1'b0, a | ~b}; q = {1'b0, a}; end
            default: begin p = {1'b0, a};      q = 17'h0FFFF; end
        endcase
        return p + q + {16'h0, cin};
    endfunction

    function automatic int latency(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Called #1 after a rising edge; offers the op and lets the next edge take it
    task automatic start_op(input int d, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] s, input logic m, input logic cin, input string tag);
        in_valid[d] = 1'b1;
        a_i[d] = a; b_i[d] = b; s_i[d] = s; m_i[d] = m; cin_i[d] = cin;
        #1;
        check_val({tag, "_in_ready"}, 32'(in_ready_o[d]), 32'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a_i[d] = 16'($urandom); b_i[d] = 16'($urandom);
        s_i[d] = 4'($urandom); m_i[d] = 1'($urandom); cin_i[d] = 1'($urandom);
    endtask

    task automatic wait_result(input int d, input logic [16:0] exp, input string tag);
        int cyc = 0;
        while (!out_valid_o[d] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'(latency(d)));
        check_val({tag, "_f"}, 32'(f_o[d]), 32'(exp[15:0]));
        check_val({tag, "_cout"}, 32'(cout_o[d]), 32'(exp[16]));
        check_val({tag, "_aeqb"}, 32'(aeqb_o[d]), 32'(exp[15:0] == 16'hFFFF));
    endtask

    task automatic hold_result(input int d, input logic [16:0] exp, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_val({tag, "_hold_valid"}, 32'(out_valid_o[d]), 32'd1);
            check_val({tag, "_hold_f"}, 32'(f_o[d]), 32'(exp[15:0]));
            check_val({tag, "_hold_cout"}, 32'(cout_o[d]), 32'(exp[16]));
            check_val({tag, "_hold_in_ready"}, 32'(in_ready_o[d]), 32'd0);
        end
    endtask

    task automatic release_result(input int d, input string tag);
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check_val({tag, "_drained"}, 32'(out_valid_o[d]), 32'd0);
    endtask

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic m, input logic cin,
                          input int hold, input string tag);
        logic [16:0] exp;
        exp = ref_alu(a, b, s, m, cin);
        start_op(d, a, b, s, m, cin, tag);
        wait_result(d, exp, tag);
        if (hold > 0) hold_result(d, exp, hold, tag);
        release_result(d, tag);
    endtask

    initial begin
        logic [16:0] exp_a, exp_b;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            a_i[d] = '0; b_i[d] = '0; s_i[d] = '0; m_i[d] = 1'b0; cin_i[d] = 1'b0;
        end
        rst = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            check_val("rst_in_ready", 32'(in_ready_o[d]), 32'd1);
            check_val("rst_out_valid", 32'(out_valid_o[d]), 32'd0);
            check_val("rst_f", 32'(f_o[d]), 32'd0);
            check_val("rst_cout", 32'(cout_o[d]), 32'd0);
            check_val("rst_aeqb", 32'(aeqb_o[d]), 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases, 4-cycle instance
        run_op(0, 16'h0020, 16'h0010, 4'b1111, 1'b0, 1'b0, 0, "dec");
        run_op(0, 16'h0020, 16'h0010, 4'b1001, 1'b0, 1'b0, 0, "add");
        run_op(0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, "add_ripple");
        run_op(0, 16'h00F0, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 0, "xor");
        run_op(0, 16'h0004, 16'h0000, 4'b0000, 1'b1, 1'b0, 0, "not_a");
        run_op(0, 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 0, "sub_eq");
        run_op(0, 16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b0, 0, "sub_ne");

        // Stall in DONE, then consume and accept in the same cycle
        exp_a = ref_alu(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        exp_b = ref_alu(16'hA5A5, 16'h0F0F, 4'b1011, 1'b1, 1'b0);
        start_op(0, 16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, "b2b_first");
        wait_result(0, exp_a, "b2b_first");
        hold_result(0, exp_a, 5, "b2b_first");
        out_ready[0] = 1'b1;
        start_op(0, 16'hA5A5, 16'h0F0F, 4'b1011, 1'b1, 1'b0, "b2b_second");
        out_ready[0] = 1'b0;
        check_val("b2b_second_busy", 32'(out_valid_o[0]), 32'd0);
        wait_result(0, exp_b, "b2b_second");
        release_result(0, "b2b_second");

        // Reset after two groups of a BUSY operation
        start_op(0, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, "midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("midrst_out_valid", 32'(out_valid_o[0]), 32'd0);
        check_val("midrst_f", 32'(f_o[0]), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready_o[0]), 32'd1);
        check_val("midrst_cout", 32'(cout_o[0]), 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val("midrst_discarded", 32'(out_valid_o[0]), 32'd0);
        end

        // Single-cycle instance, same additions
        run_op(1, 16'h0020, 16'h0010, 4'b1001, 1'b0, 1'b0, 0, "l4_add");
        run_op(1, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0, "l4_add_ripple");
        run_op(1, 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, 1, "l4_sub_eq");

        // Randomized operations on both instances
        for (int i = 0; i < 40; i++) begin
            run_op(0, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "rnd_l1");
        end
        for (int i = 0; i < 40; i++) begin
            run_op(1, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), "rnd_l4");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
